alu_op_sequencer: RTL and testbench
===================================

# alu_op_sequencer

Sequencing controller for the shared 4-bit ALU (AND/OR/XOR/ADD/SUB/shift units with Z/N/C/V flags) on the FPGA board. It collects operand A, operand B and an opcode from four data switches, one button press each. It then drives the combinational ALU for a fixed settle window and registers the result and flags for display. It sits between the board I/O (switches, debounced button, LEDs/7-seg) and the ALU datapath.

## Interface

- SETTLE_CYCLES, default 1: cycles that ALU inputs are held stable before capture; legal range 1..15.
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- sw  in  4  data switches; sampled as A, then B, then opcode (sw[2:0]).
- btn  in  1  "next" button; already synchronized and debounced upstream, level signal.
- alu_r  in  4  ALU result (combinational).
- alu_flags  in  4  ALU flags {Z,N,C,V} (combinational).
- alu_a  out  4  operand A to ALU.
- alu_b  out  4  operand B to ALU.
- alu_op  out  3  opcode to ALU: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR, 111 reserved.
- result  out  4  registered ALU result.
- flags  out  4  registered {Z,N,C,V}.
- state_o  out  3  current FSM state code, for LED debug.
- done  out  1  high while in SHOW.
- err  out  1  high while in ERR.

## Operation

- Edge detect: btn_q is a register of btn. press = btn & ~btn_q. btn_q resets to 1, so a button held through reset does not generate a press.
- FSM states and codes: IDLE=0, GET_B=1, GET_OP=2, EXEC=3, SHOW=4, ERR=5. Codes 6 and 7 are unreachable and go to IDLE on the next cycle.
- IDLE: on press, a_reg <= sw, then go to GET_B.
- GET_B: on press, b_reg <= sw, then go to GET_OP.
- GET_OP: on press, op_reg <= sw[2:0].
  - If sw[2:0]==111, go to ERR.
  - Otherwise, go to EXEC with cnt <= 0.
- EXEC: alu_a/alu_b/alu_op hold a_reg/b_reg/op_reg.
  - cnt increments each cycle.
  - When cnt==SETTLE_CYCLES-1: result <= alu_r, flags <= alu_flags, then go to SHOW.
  - Presses are ignored.
- SHOW: done=1. result and flags are held. On press, go to IDLE.
- ERR: err=1. result and flags are unchanged from the prior operation. On press, go to IDLE.
- alu_a, alu_b and alu_op are driven continuously from a_reg, b_reg and op_reg in every state.
- result and flags change only at the EXEC capture or at reset. They persist across IDLE, GET_B and GET_OP so the last answer stays displayed.
- A press in a state not listed above has no effect. One press advances at most one state.
- cnt is 4 bits wide and is cleared on EXEC entry.

## Timing

- Reset: state=IDLE; a_reg=b_reg=0; op_reg=000; cnt=0; result=0; flags=0; done=0; err=0; btn_q=1; alu_a=alu_b=0; alu_op=000.
- A reset asserted in any state, including mid-EXEC, takes effect on the next edge. A capture pending in that cycle does not occur.
- Press latency: with btn rising before edge k, press is high in cycle k and the state changes at edge k+1.
- Execution latency: the GET_OP press is seen in cycle k, and EXEC starts at k+1.
  - Capture happens at edge k+1+SETTLE_CYCLES.
  - done rises in the same cycle that result becomes valid.
  - For SETTLE_CYCLES=1, done rises 2 cycles after the press cycle.
- done and err are Moore outputs, decoded from state only.

## Test plan

- Reset, then A=0xC, B=0xA, op=010 (AND) -> result=0x8, flags=0100 (N=1), done=1, state_o=4.
- A=0x0, B=0xF, op=010 -> result=0x0, flags=1000 (Z=1). Then press in SHOW -> state IDLE, result stays 0x0.
- op=111 after any A/B -> state ERR, err=1, done=0, result/flags unchanged from the previous capture. Press -> IDLE.
- SETTLE_CYCLES=3, and alu_r changes to a wrong value during the first two EXEC cycles -> only the value on the third EXEC cycle is captured. done asserts 4 cycles after the GET_OP press cycle.
- Hold btn high for 10 cycles in IDLE -> exactly one state advance (to GET_B). btn held through reset release -> no advance.
- Assert rst during EXEC -> next cycle state=IDLE, result=0, flags=0, alu_a=alu_b=0, done=0.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - collects A, B and opcode from switches, runs the ALU for a settle window, shows the result
module alu_op_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sw,
  input  logic       btn,
  input  logic [3:0] alu_r,
  input  logic [3:0] alu_flags,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [2:0] alu_op,
  output logic [3:0] result,
  output logic [3:0] flags,
  output logic [2:0] state_o,
  output logic       done,
  output logic       err
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    GET_B  = 3'd1,
    GET_OP = 3'd2,
    EXEC   = 3'd3,
    SHOW   = 3'd4,
    ERR    = 3'd5
  } state_t;

  localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);

  state_t     state_q, state_d;
  logic [3:0] a_q, a_d;
  logic [3:0] b_q, b_d;
  logic [2:0] op_q, op_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] result_q, result_d;
  logic [3:0] flags_q, flags_d;
  logic       btn_q;
  logic       done_q;
  logic       err_q;
  logic       press;

  assign press = btn & ~btn_q;

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    flags_d  = flags_q;
    case (state_q)
      IDLE: begin
        if (press) begin
          a_d     = sw;
          state_d = GET_B;
        end
      end
      GET_B: begin
        if (press) begin
          b_d     = sw;
          state_d = GET_OP;
        end
      end
      GET_OP: begin
        if (press) begin
          op_d = sw[2:0];
          if (sw[2:0] == 3'b111) begin
            state_d = ERR;
          end else begin
            state_d = EXEC;
            cnt_d   = 4'd0;
          end
        end
      end
      EXEC: begin
        // ALU inputs have been stable for the whole window by the last count
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == CNT_LAST) begin
          result_d = alu_r;
          flags_d  = alu_flags;
          state_d  = SHOW;
        end
      end
      SHOW, ERR: begin
        if (press) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= 4'd0;
      b_q      <= 4'd0;
      op_q     <= 3'd0;
      cnt_q    <= 4'd0;
      result_q <= 4'd0;
      flags_q  <= 4'd0;
      btn_q    <= 1'b1;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      btn_q    <= btn;
      done_q   <= (state_d == SHOW);
      err_q    <= (state_d == ERR);
    end
  end

  assign alu_a   = a_q;
  assign alu_b   = b_q;
  assign alu_op  = op_q;
  assign result  = result_q;
  assign flags   = flags_q;
  assign state_o = state_q;
  assign done    = done_q;
  assign err     = err_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - directed bench for alu_op_sequencer with settle windows of 1 and 3
`timescale 1ns/1ps
module tb_alu_op_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] sw;
  logic       btn;
  logic [3:0] alu_r;
  logic [3:0] alu_flags;

  logic [3:0] a1, b1, r1, f1, a3, b3, r3, f3;
  logic [2:0] op1, st1, op3, st3;
  logic       d1, e1, d3, e3;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_op_sequencer #(.SETTLE_CYCLES(1)) u1 (
    .clk(clk), .rst(rst), .sw(sw), .btn(btn), .alu_r(alu_r), .alu_flags(alu_flags),
    .alu_a(a1), .alu_b(b1), .alu_op(op1), .result(r1), .flags(f1),
    .state_o(st1), .done(d1), .err(e1)
  );

  alu_op_sequencer #(.SETTLE_CYCLES(3)) u3 (
    .clk(clk), .rst(rst), .sw(sw), .btn(btn), .alu_r(alu_r), .alu_flags(alu_flags),
    .alu_a(a3), .alu_b(b3), .alu_op(op3), .result(r3), .flags(f3),
    .state_o(st3), .done(d3), .err(e3)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic press(input logic [3:0] v);
    sw  = v;
    btn = 1'b1;
    step();
    btn = 1'b0;
    step();
  endtask

  initial begin
    rst = 1'b1; btn = 1'b0; sw = 4'd0; alu_r = 4'd0; alu_flags = 4'd0;
    step();
    step();
    rst = 1'b0;
    step();
    check("rst_state", 8'(st1), 8'd0);
    check("rst_result", 8'(r1), 8'd0);
    check("rst_flags", 8'(f1), 8'd0);
    check("rst_done", 8'(d1), 8'd0);
    check("rst_err", 8'(e1), 8'd0);
    check("rst_alu_a", 8'(a1), 8'd0);
    check("rst_alu_op", 8'(op1), 8'd0);

    // C AND A = 8, N set
    alu_r = 4'h8; alu_flags = 4'b0100;
    press(4'hC);
    check("getb_state", 8'(st1), 8'd1);
    press(4'hA);
    check("getop_state", 8'(st1), 8'd2);
    press(4'h2);
    check("and_state", 8'(st1), 8'd4);
    check("and_done", 8'(d1), 8'd1);
    check("and_result", 8'(r1), 8'h8);
    check("and_flags", 8'(f1), 8'h4);
    check("and_alu_a", 8'(a1), 8'hC);
    check("and_alu_b", 8'(b1), 8'hA);
    check("and_alu_op", 8'(op1), 8'h2);
    check("and3_exec", 8'(st3), 8'd3);
    step();
    step();
    check("and3_done", 8'(d3), 8'd1);
    check("and3_result", 8'(r3), 8'h8);

    press(4'h0);
    check("show_to_idle", 8'(st1), 8'd0);
    check("idle_result_held", 8'(r1), 8'h8);

    // 0 AND F = 0, Z set
    alu_r = 4'h0; alu_flags = 4'b1000;
    press(4'h0);
    press(4'hF);
    press(4'h2);
    step();
    step();
    check("zero_result", 8'(r1), 8'h0);
    check("zero_flags", 8'(f1), 8'h8);
    check("zero3_flags", 8'(f3), 8'h8);
    press(4'h0);
    check("zero_idle", 8'(st1), 8'd0);
    check("zero_idle_result", 8'(r1), 8'h0);

    // reserved opcode
    alu_r = 4'h5; alu_flags = 4'b0001;
    press(4'h3);
    press(4'h4);
    press(4'h7);
    check("err_state", 8'(st1), 8'd5);
    check("err_flag", 8'(e1), 8'd1);
    check("err_done", 8'(d1), 8'd0);
    check("err_result", 8'(r1), 8'h0);
    check("err_flags", 8'(f1), 8'h8);
    check("err3_state", 8'(st3), 8'd5);
    press(4'h0);
    check("err_idle", 8'(st1), 8'd0);
    check("err_cleared", 8'(e1), 8'd0);

    // settle window: only the third EXEC cycle value is captured by u3
    press(4'h9);
    press(4'h3);
    sw = 4'h0; btn = 1'b1; alu_r = 4'h1; alu_flags = 4'b0001;
    step();
    btn = 1'b0;
    step();
    check("s1_result_first", 8'(r1), 8'h1);
    check("s1_done", 8'(d1), 8'd1);
    check("s3_exec1", 8'(st3), 8'd3);
    check("s3_done1", 8'(d3), 8'd0);
    alu_r = 4'h2; alu_flags = 4'b0010;
    step();
    check("s3_done2", 8'(d3), 8'd0);
    alu_r = 4'hC; alu_flags = 4'b0100;
    step();
    check("s3_done3", 8'(d3), 8'd1);
    check("s3_result", 8'(r3), 8'hC);
    check("s3_flags", 8'(f3), 8'h4);
    alu_r = 4'hF;
    step();
    check("s3_show_held", 8'(r3), 8'hC);
    press(4'h0);
    check("s3_idle", 8'(st3), 8'd0);

    // long hold advances once
    sw = 4'h6; btn = 1'b1;
    for (int i = 0; i < 10; i++) step();
    btn = 1'b0;
    step();
    check("hold_state", 8'(st1), 8'd1);
    check("hold_alu_a", 8'(a1), 8'h6);

    // reset mid-EXEC drops the pending capture
    alu_r = 4'h7; alu_flags = 4'b0000;
    press(4'h1);
    sw = 4'h0; btn = 1'b1;
    step();
    check("pre_rst_exec", 8'(st1), 8'd3);
    btn = 1'b0; rst = 1'b1;
    step();
    check("rst_exec_state", 8'(st1), 8'd0);
    check("rst_exec_result", 8'(r1), 8'h0);
    check("rst_exec_flags", 8'(f1), 8'h0);
    check("rst_exec_alu_a", 8'(a1), 8'h0);
    check("rst_exec_done", 8'(d1), 8'd0);
    check("rst3_result", 8'(r3), 8'h0);
    check("rst3_alu_b", 8'(b3), 8'h0);

    // button held through reset release
    btn = 1'b1;
    step();
    rst = 1'b0;
    step();
    step();
    step();
    check("held_rst_state", 8'(st1), 8'd0);
    btn = 1'b0;
    step();
    check("held_rst_release", 8'(st1), 8'd0);
    press(4'h5);
    check("post_rst_press", 8'(st1), 8'd1);
    check("post_rst_alu_a", 8'(a1), 8'h5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
